// File: rtl/decode_stage_ctrl.sv
// Registered RV32I/RV64I decode stage: valid/ready handshake, 2-entry skid, flush, illegal flag, PC passthrough, handshake counter.
// Output appears 1 cycle after an input handshake; InReady drops while the skid holds an entry; outputs are held while stalled.
package decode_stage_ctrl_pkg;
  typedef enum logic [1:0] {PCp4_I, PCUPD_I, PCCOND_I} pc_src_t;
  typedef enum logic [2:0] {NO_BRANCH, BEQ_C, BNE_C, BLT_C, BGE_C, BLTU_C, BGEU_C} cond_pc_src_t;
  typedef enum logic [2:0] {ImmNone, Imm11t0, Imm4t0, Imm5t0, ImmS, ImmB, ImmU, ImmJ} imm_src_t;
  typedef enum logic {UPD_PC_IMM, UPD_RS1_IMM} upd_pc_src_t;
  typedef enum logic {SRCB_REG, SRCB_IMM} alu_src_b_t;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB} alu_op_t;
  typedef enum logic [1:0] {COMP_ALU, COMP_PC_IMM, COMP_PC_P4} compute_src_t;
  typedef enum logic {RES_COMPUTE, RES_MEM} result_src_t;
  typedef enum logic [2:0] {NO_TRUNC, BYTE, HALF_WORD, WORD, BYTE_UNSIGNED,
                            HALF_WORD_UNSIGNED, WORD_UNSIGNED} trunc_src_t;
endpackage

module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instr,
  input  logic [PC_W-1:0]   InPC,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [PC_W-1:0]   OutPC,
  output logic              RegWrite,
  output logic              MemEn,
  output logic              MemWrite,
  output logic [XLEN/8-1:0] ByteEn,
  output pc_src_t           PCSrc,
  output cond_pc_src_t      ConditionalPCSrc,
  output imm_src_t          ImmSrc,
  output upd_pc_src_t       UpdatedPCSrc,
  output alu_src_b_t        ALUSrcB,
  output alu_op_t           ALUOp,
  output compute_src_t      ComputeSrc,
  output result_src_t       ResultSrc,
  output trunc_src_t        TruncSrc,
  output logic              WordOp,
  output logic              Illegal,
  output logic [CNT_W-1:0]  DecodeCount
);
  localparam int       BW   = XLEN / 8;
  localparam bit       IS64 = (XLEN == 64);
  localparam imm_src_t C_SHAMT_IMM = IS64 ? Imm5t0 : Imm4t0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            reg_write;
    logic            mem_en;
    logic            mem_write;
    logic [BW-1:0]   byte_en;
    pc_src_t         pc_src;
    cond_pc_src_t    cond_pc_src;
    imm_src_t        imm_src;
    upd_pc_src_t     upd_pc_src;
    alu_src_b_t      alu_src_b;
    alu_op_t         alu_op;
    compute_src_t    compute_src;
    result_src_t     result_src;
    trunc_src_t      trunc_src;
    logic            word_op;
    logic            illegal;
  } entry_t;

  entry_t           r_main, r_skid, w_dec;
  logic             r_main_vld, r_skid_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ill, w_in_hs, w_out_hs, w_b25_ok, w_unused;
  logic [6:0]       w_opc, w_f7;
  logic [2:0]       w_f3;

  assign w_opc    = Instr[6:0];
  assign w_f3     = Instr[14:12];
  assign w_f7     = Instr[31:25];
  // shamt[5] lives in bit 25, which is reserved on RV32
  assign w_b25_ok = IS64 || !Instr[25];
  assign w_unused = ^{Instr[24:15], Instr[11:7]};

  always_comb begin
    w_dec    = '0;
    w_ill    = 1'b0;
    w_dec.pc = InPC;
    case (w_opc)
      7'b0110011: begin
        w_dec.reg_write = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_dec.alu_op = ALU_ADD;
            3'b001:  w_dec.alu_op = ALU_SLL;
            3'b010:  w_dec.alu_op = ALU_SLT;
            3'b011:  w_dec.alu_op = ALU_SLTU;
            3'b100:  w_dec.alu_op = ALU_XOR;
            3'b101:  w_dec.alu_op = ALU_SRL;
            3'b110:  w_dec.alu_op = ALU_OR;
            default: w_dec.alu_op = ALU_AND;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_dec.alu_op = ALU_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_dec.alu_op = ALU_SRA;
        end else begin
          w_ill = 1'b1;
        end
      end
      7'b0010011: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src_b = SRCB_IMM;
        w_dec.imm_src   = Imm11t0;
        case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b010: w_dec.alu_op = ALU_SLT;
          3'b011: w_dec.alu_op = ALU_SLTU;
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b110: w_dec.alu_op = ALU_OR;
          3'b111: w_dec.alu_op = ALU_AND;
          3'b001: begin
            w_dec.alu_op  = ALU_SLL;
            w_dec.imm_src = C_SHAMT_IMM;
            w_ill         = !(Instr[31:26] == 6'b000000 && w_b25_ok);
          end
          default: begin
            w_dec.alu_op  = Instr[30] ? ALU_SRA : ALU_SRL;
            w_dec.imm_src = C_SHAMT_IMM;
            w_ill         = !((Instr[31:26] == 6'b000000 || Instr[31:26] == 6'b010000) && w_b25_ok);
          end
        endcase
      end
      7'b0011011: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src_b = SRCB_IMM;
        w_dec.word_op   = 1'b1;
        w_dec.imm_src   = Imm4t0;
        if (!IS64) w_ill = 1'b1;
        else if (w_f3 == 3'b000) begin
          w_dec.alu_op  = ALU_ADD;
          w_dec.imm_src = Imm11t0;
        end else if (w_f3 == 3'b001 && w_f7 == 7'b0000000) w_dec.alu_op = ALU_SLL;
        else if (w_f3 == 3'b101 && w_f7 == 7'b0000000) w_dec.alu_op = ALU_SRL;
        else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_dec.alu_op = ALU_SRA;
        else w_ill = 1'b1;
      end
      7'b0111011: begin
        w_dec.reg_write = 1'b1;
        w_dec.word_op   = 1'b1;
        if (!IS64) w_ill = 1'b1;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b000) w_dec.alu_op = ALU_ADD;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b001) w_dec.alu_op = ALU_SLL;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b101) w_dec.alu_op = ALU_SRL;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_dec.alu_op = ALU_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_dec.alu_op = ALU_SRA;
        else w_ill = 1'b1;
      end
      7'b0000011: begin
        w_dec.reg_write  = 1'b1;
        w_dec.mem_en     = 1'b1;
        w_dec.result_src = RES_MEM;
        w_dec.alu_src_b  = SRCB_IMM;
        w_dec.imm_src    = Imm11t0;
        case (w_f3)
          3'b000:  w_dec.trunc_src = BYTE;
          3'b001:  w_dec.trunc_src = HALF_WORD;
          3'b010:  w_dec.trunc_src = WORD;
          3'b100:  w_dec.trunc_src = BYTE_UNSIGNED;
          3'b101:  w_dec.trunc_src = HALF_WORD_UNSIGNED;
          3'b110:  begin w_dec.trunc_src = WORD_UNSIGNED; w_ill = !IS64; end
          3'b011:  begin w_dec.trunc_src = NO_TRUNC;      w_ill = !IS64; end
          default: w_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_dec.mem_en    = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.alu_src_b = SRCB_IMM;
        w_dec.imm_src   = ImmS;
        case (w_f3)
          3'b000:  w_dec.byte_en = BW'(8'h01);
          3'b001:  w_dec.byte_en = BW'(8'h03);
          3'b010:  w_dec.byte_en = BW'(8'h0F);
          3'b011:  begin w_dec.byte_en = BW'(8'hFF); w_ill = !IS64; end
          default: w_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_dec.pc_src  = PCCOND_I;
        w_dec.imm_src = ImmB;
        w_dec.alu_op  = ALU_SUB;
        case (w_f3)
          3'b000:  w_dec.cond_pc_src = BEQ_C;
          3'b001:  w_dec.cond_pc_src = BNE_C;
          3'b100:  w_dec.cond_pc_src = BLT_C;
          3'b101:  w_dec.cond_pc_src = BGE_C;
          3'b110:  w_dec.cond_pc_src = BLTU_C;
          3'b111:  w_dec.cond_pc_src = BGEU_C;
          default: w_ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        w_dec.reg_write   = 1'b1;
        w_dec.pc_src      = PCUPD_I;
        w_dec.upd_pc_src  = UPD_PC_IMM;
        w_dec.imm_src     = ImmJ;
        w_dec.compute_src = COMP_PC_P4;
      end
      7'b1100111: begin
        w_dec.reg_write   = 1'b1;
        w_dec.pc_src      = PCUPD_I;
        w_dec.upd_pc_src  = UPD_RS1_IMM;
        w_dec.imm_src     = Imm11t0;
        w_dec.compute_src = COMP_PC_P4;
        w_ill             = (w_f3 != 3'b000);
      end
      7'b0110111: begin
        w_dec.reg_write = 1'b1;
        w_dec.imm_src   = ImmU;
        w_dec.alu_src_b = SRCB_IMM;
        w_dec.alu_op    = ALU_PASSB;
      end
      7'b0010111: begin
        w_dec.reg_write   = 1'b1;
        w_dec.imm_src     = ImmU;
        w_dec.compute_src = COMP_PC_IMM;
      end
      default: w_ill = 1'b1;
    endcase
    // an illegal entry must never write state or redirect the PC
    if (w_ill) begin
      w_dec.reg_write   = 1'b0;
      w_dec.mem_en      = 1'b0;
      w_dec.mem_write   = 1'b0;
      w_dec.byte_en     = '0;
      w_dec.pc_src      = PCp4_I;
      w_dec.cond_pc_src = NO_BRANCH;
      w_dec.word_op     = 1'b0;
    end
    w_dec.illegal = w_ill;
  end

  assign w_in_hs  = InValid && !r_skid_vld;
  assign w_out_hs = r_main_vld && OutReady;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
      if (Flush) begin
        r_main_vld <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (w_out_hs) begin
        // skid occupied implies InReady was low, so no input competes with the refill
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_skid_vld <= 1'b0;
        end else if (w_in_hs) begin
          r_main <= w_dec;
        end else begin
          r_main_vld <= 1'b0;
        end
      end else if (!r_main_vld) begin
        if (w_in_hs) begin
          r_main     <= w_dec;
          r_main_vld <= 1'b1;
        end
      end else if (w_in_hs) begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign InReady          = !r_skid_vld;
  assign OutValid         = r_main_vld;
  assign OutPC            = r_main.pc;
  assign RegWrite         = r_main.reg_write;
  assign MemEn            = r_main.mem_en;
  assign MemWrite         = r_main.mem_write;
  assign ByteEn           = r_main.byte_en;
  assign PCSrc            = r_main.pc_src;
  assign ConditionalPCSrc = r_main.cond_pc_src;
  assign ImmSrc           = r_main.imm_src;
  assign UpdatedPCSrc     = r_main.upd_pc_src;
  assign ALUSrcB          = r_main.alu_src_b;
  assign ALUOp            = r_main.alu_op;
  assign ComputeSrc       = r_main.compute_src;
  assign ResultSrc        = r_main.result_src;
  assign TruncSrc         = r_main.trunc_src;
  assign WordOp           = r_main.word_op;
  assign Illegal          = r_main.illegal;
  assign DecodeCount      = r_cnt;
endmodule
